// File: rtl/press_pkg.sv
// press_classifier shared types and defaults.
// State codes are 3 bits; cycle defaults assume a 100 MHz clock.
package press_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    HELD     = 3'd2,
    WAIT2    = 3'd3,
    PRESSED2 = 3'd4
  } state_t;

  localparam int CW_DEF     = 26;
  localparam int LONG_DEF   = 50_000_000;
  localparam int DOUBLE_DEF = 25_000_000;
  localparam int REPEAT_DEF = 10_000_000;

endpackage

// File: rtl/press_classifier_if.sv
// Debounced button in, gesture event pulses out.
// master drives the button side, slave is the classifier.
interface press_classifier_if;

  logic db_tick;
  logic db_level;
  logic short_tick;
  logic double_tick;
  logic long_tick;
  logic repeat_tick;
  logic busy;

  modport master (
    output db_tick, db_level,
    input  short_tick, double_tick,
    input  long_tick, repeat_tick, busy
  );

  modport slave (
    input  db_tick, db_level,
    output short_tick, double_tick,
    output long_tick, repeat_tick, busy
  );

endinterface

// File: rtl/cycle_timer.sv
// Clearable up-counter with terminal-count compare.
// done is high while the count equals the runtime limit.
module cycle_timer #(
  parameter int CW = 26
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = (cnt == limit);

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced presses into short, double, long
// and auto-repeat single-cycle events.
module press_classifier
  import press_pkg::*;
#(
  parameter int CW            = CW_DEF,
  parameter int LONG_CYCLES   = LONG_DEF,
  parameter int DOUBLE_WIN    = DOUBLE_DEF,
  parameter int REPEAT_CYCLES = REPEAT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  press_classifier_if.slave bus
);

  state_t        state, nxt;
  logic          clr, en, done;
  logic [CW-1:0] limit;
  logic          short_n, double_n;
  logic          long_n, repeat_n;

  // one timer serves every state; only the limit changes
  always_comb begin
    case (state)
      PRESSED: limit = CW'(LONG_CYCLES - 1);
      HELD:    limit = CW'(REPEAT_CYCLES - 1);
      default: limit = CW'(DOUBLE_WIN - 1);
    endcase
  end

  cycle_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .en      (en),
    .limit   (limit),
    .done    (done)
  );

  always_comb begin
    nxt      = state;
    clr      = 1'b0;
    en       = 1'b0;
    short_n  = 1'b0;
    double_n = 1'b0;
    long_n   = 1'b0;
    repeat_n = 1'b0;
    case (state)
      IDLE: begin
        clr = 1'b1;
        if (bus.db_tick) nxt = PRESSED;
      end
      PRESSED: begin
        if (!bus.db_level) begin
          nxt = WAIT2;
          clr = 1'b1;
        end else if (done) begin
          long_n = 1'b1;
          nxt    = HELD;
          clr    = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
      HELD: begin
        if (!bus.db_level) begin
          nxt = IDLE;
          clr = 1'b1;
        end else if (done) begin
          repeat_n = 1'b1;
          clr      = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
      WAIT2: begin
        if (bus.db_tick) begin
          double_n = 1'b1;
          nxt      = PRESSED2;
          clr      = 1'b1;
        end else if (done) begin
          short_n = 1'b1;
          nxt     = IDLE;
          clr     = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
      PRESSED2: begin
        clr = 1'b1;
        if (!bus.db_level) nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
        clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus.short_tick  <= 1'b0;
      bus.double_tick <= 1'b0;
      bus.long_tick   <= 1'b0;
      bus.repeat_tick <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= nxt;
      bus.short_tick  <= short_n;
      bus.double_tick <= double_n;
      bus.long_tick   <= long_n;
      bus.repeat_tick <= repeat_n;
      bus.busy        <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// Scenario table plus randomized gestures checked
// against a timestamp-based model of the gesture rules.
module tb_press_classifier;

  localparam int LC = 8;
  localparam int DW = 6;
  localparam int RC = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  press_classifier_if bus ();

  press_classifier #(
    .CW            (4),
    .LONG_CYCLES   (LC),
    .DOUBLE_WIN    (DW),
    .REPEAT_CYCLES (RC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef enum {G_IDLE, G_FIRST, G_HOLD, G_GAP, G_SECOND} phase_t;
  phase_t     ph = G_IDLE;
  int         n  = 0;
  int         t0 = 0;
  int         tr = 0;
  logic [4:0] exp_o;

  function automatic logic [4:0] got();
    return {bus.short_tick, bus.double_tick,
            bus.long_tick, bus.repeat_tick, bus.busy};
  endfunction

  // exp_o = {short, double, long, repeat, busy}
  task automatic model_edge(input logic tk, input logic lv,
                            input logic rs);
    logic s, d, l, r;
    s = 0; d = 0; l = 0; r = 0;
    if (!rs) begin
      ph = G_IDLE;
    end else begin
      case (ph)
        G_IDLE: if (tk) begin ph = G_FIRST; t0 = n; end
        G_FIRST:
          if (!lv) begin ph = G_GAP; tr = n; end
          else if (n - t0 == LC) begin l = 1; ph = G_HOLD; end
        G_HOLD:
          if (!lv) ph = G_IDLE;
          else if ((n - t0 - LC) % RC == 0) r = 1;
        G_GAP:
          if (tk) begin d = 1; ph = G_SECOND; end
          else if (n - tr == DW) begin s = 1; ph = G_IDLE; end
        G_SECOND: if (!lv) ph = G_IDLE;
        default: ph = G_IDLE;
      endcase
    end
    exp_o = {s, d, l, r, ph != G_IDLE};
  endtask

  task automatic drive_edge(input logic tk, input logic lv,
                            input logic rs);
    bus.db_tick  = tk;
    bus.db_level = lv;
    reset_n      = rs;
    @(posedge clk);
    n++;
    model_edge(tk, lv, rs);
    #1;
  endtask

  task automatic check(input string nm, input int k,
                       input logic [4:0] want);
    logic [4:0] g;
    g = got();
    checks++;
    if (g !== want) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b want=%b", nm, k, g, want);
    end
  endtask

  typedef struct {
    string nm;
    int rel; int tk2; int rel2; int rst;
    int sh; int db; int lg; int r1; int r2; int bend;
  } scen_t;

  scen_t tbl [6];

  initial begin
    logic       tk, lv, rs;
    logic [4:0] want;

    tbl[0] = '{"short",    4, -1, -1, -1, 10, -1, -1, -1, -1, 10};
    tbl[1] = '{"double",   4,  7,  9, -1, -1,  7, -1, -1, -1,  9};
    tbl[2] = '{"long_rep",18, -1, -1, -1, -1, -1,  8, 12, 16, 18};
    tbl[3] = '{"long_bnd", 8, -1, -1, -1, 14, -1, -1, -1, -1, 14};
    tbl[4] = '{"win_tie",  4, 10, 12, -1, -1, 10, -1, -1, -1, 12};
    tbl[5] = '{"rst_wait", 4, -1, -1,  6, -1, -1, -1, -1, -1,  6};

    drive_edge(0, 0, 0);
    check("reset", 0, 5'b0);

    foreach (tbl[i]) begin
      drive_edge(0, 0, 0);
      drive_edge(0, 0, 1);
      drive_edge(0, 0, 1);
      for (int k = 0; k <= 22; k++) begin
        tk = (k == 0) || (k == tbl[i].tk2);
        lv = (k >= 1 && k < tbl[i].rel) ||
             (tbl[i].tk2 >= 0 && k > tbl[i].tk2 && k < tbl[i].rel2);
        rs = (k != tbl[i].rst);
        drive_edge(tk, lv, rs);
        want = {k == tbl[i].sh, k == tbl[i].db, k == tbl[i].lg,
                k == tbl[i].r1 || k == tbl[i].r2, k < tbl[i].bend};
        check(tbl[i].nm, k, want);
      end
    end

    // ignored tick while held after a double
    drive_edge(0, 0, 0);
    drive_edge(1, 0, 1);
    drive_edge(0, 1, 1);
    drive_edge(0, 0, 1);
    drive_edge(1, 0, 1);
    check("dbl_seq", 0, 5'b01001);
    drive_edge(1, 1, 1);
    check("dbl_held_tick", 1, 5'b00001);
    for (int k = 0; k < 12; k++) drive_edge(0, 1, 1);
    check("dbl_no_long", 2, 5'b00001);
    drive_edge(0, 0, 1);
    check("dbl_release", 3, 5'b00000);

    drive_edge(0, 0, 0);
    check("rand_reset", 0, exp_o);
    for (int g = 0; g < 300; g++) begin
      int gap, hold;
      gap  = $urandom_range(0, 9);
      hold = $urandom_range(1, 22);
      for (int k = 0; k < gap; k++) begin
        drive_edge(0, 0, $urandom_range(0, 199) != 0);
        check("rand_gap", n, exp_o);
      end
      drive_edge(1, 0, 1);
      check("rand_tick", n, exp_o);
      for (int k = 0; k < hold; k++) begin
        drive_edge($urandom_range(0, 9) == 0, 1,
                   $urandom_range(0, 199) != 0);
        check("rand_hold", n, exp_o);
      end
    end
    for (int k = 0; k < 8; k++) begin
      drive_edge(0, 0, 1);
      check("rand_tail", n, exp_o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
# press_classifier

Consumes the debounced button outputs (`db_tick` single-cycle press pulse, `db_level` held level) and classifies each gesture as short press, double press, long press, or auto-repeat while held. Sits directly downstream of the button debouncer, one instance per button, and feeds single-cycle event pulses to the control FSMs. All outputs are registered; exactly one event class fires per gesture, except repeats, which follow a long press.

## Interface
- `CW`, 26: counter width; every cycle parameter must be ≥2 and < 2^CW.
- `LONG_CYCLES`, 50_000_000: hold time that qualifies a long press (500 ms at 100 MHz).
- `DOUBLE_WIN`, 25_000_000: window after a short release for a second press (250 ms).
- `REPEAT_CYCLES`, 10_000_000: auto-repeat period while held after a long press (100 ms).

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  reset; one clock, synchronous and active-low.
- `db_tick`  in  1  one-cycle pulse on debounced press; `db_level` rises the cycle after.
- `db_level`  in  1  debounced button level, 1 = pressed.
- `short_tick`  out  1  one-cycle pulse: single short press confirmed.
- `double_tick`  out  1  one-cycle pulse: second press inside window.
- `long_tick`  out  1  one-cycle pulse: hold reached `LONG_CYCLES`.
- `repeat_tick`  out  1  one-cycle pulse every `REPEAT_CYCLES` while held after long.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, PRESSED, HELD, WAIT2, PRESSED2. One counter `cnt[CW-1:0]`, cleared on every state change.
- IDLE: `db_tick`=1 → PRESSED. `db_level` is ignored in IDLE.
- PRESSED: `db_level`=0 → WAIT2. Otherwise, if `cnt`==`LONG_CYCLES`-1 → `long_tick`, HELD. Otherwise `cnt`++. Release takes priority over long on the same edge.
- HELD: `db_level`=0 → IDLE, with no event. Otherwise, if `cnt`==`REPEAT_CYCLES`-1 → `repeat_tick`, `cnt`=0. Otherwise `cnt`++.
- WAIT2: `db_tick`=1 → `double_tick`, PRESSED2. Otherwise, if `cnt`==`DOUBLE_WIN`-1 → `short_tick`, IDLE. Otherwise `cnt`++. `db_tick` takes priority over timeout on the same edge.
- PRESSED2: `db_level`=0 → IDLE. Hold length is ignored, so there is no long or repeat after a double.
- `db_tick` outside IDLE and WAIT2 is ignored.
- Counter never wraps; compares are equality against the parameter minus 1.

## Timing
- Reset: on an edge with `reset_n`=0, the block goes to IDLE and sets `cnt`=0 and all outputs to 0. This includes mid-gesture; a pending short is discarded.
- All ticks are registered. Each is high for exactly the one cycle following the deciding edge.
- Let E0 be the edge sampling `db_tick`=1 in IDLE.
- Long: `long_tick` follows edge E0+`LONG_CYCLES`, given `db_level`=1 on edges E0+1 through E0+`LONG_CYCLES`.
- Repeats follow edges E0+`LONG_CYCLES`+k·`REPEAT_CYCLES` for k ≥ 1 while held.
- Short: if release is sampled at edge Er, `short_tick` follows Er+`DOUBLE_WIN` unless `db_tick` is sampled on any edge Er+1 through Er+`DOUBLE_WIN`. In that case `double_tick` follows that edge.
- `busy` is registered and updates with the state: high the cycle after E0, low the cycle after returning to IDLE.

## Structure
- Shared package `press_pkg`: state encoding constants (3-bit) and the default cycle constants at 100 MHz.
- One sub-module is natural: `cycle_timer` (clear, enable, terminal-count compare against a runtime limit input, `CW` wide). One instance is reused across states by muxing the limit.
- The rest is a single FSM with registered outputs.

## Test plan
All scenarios use `CW`=4, `LONG_CYCLES`=8, `DOUBLE_WIN`=6, `REPEAT_CYCLES`=4.
- Short: tick at E0, `db_level` high E1–E3, low from E4 → `short_tick` after E10 only; `busy` low after E10.
- Double: same first press, second `db_tick` at E7 → `double_tick` after E7; no `short_tick`. Release at E9 → IDLE.
- Long + repeat: tick E0, held through E17, low at E18 → `long_tick` after E8, `repeat_tick` after E12 and E16; no short or double.
- Long boundary: `db_level` falls exactly at E8 → no `long_tick`; WAIT2, then `short_tick` after E14.
- Window tie: release at E4, `db_tick` at E10 (`cnt`==5) → `double_tick`, no `short_tick`.
- Reset mid-WAIT2: `reset_n`=0 at E6 for one edge → all outputs 0 and `busy`=0 after E6; no `short_tick` at E10.
